// File: rtl/sub_mp_seq_if.sv
// Request/result handshake bundle for the multi-precision subtract sequencer.
// The issue side drives the request; the sequencer returns the result.
interface sub_mp_seq_if #(
  parameter int WORDS = 4
);
  logic                  start_valid;
  logic                  start_ready;
  logic [32*WORDS-1:0]   a;
  logic [32*WORDS-1:0]   b;
  logic                  bin;
  logic [32*WORDS-1:0]   res;
  logic                  bout;
  logic                  zero;
  logic                  done_valid;
  logic                  done_ready;

  modport master (
    output start_valid, a, b, bin, done_ready,
    input  start_ready, res, bout, zero, done_valid
  );

  modport slave (
    input  start_valid, a, b, bin, done_ready,
    output start_ready, res, bout, zero, done_valid
  );
endinterface

// File: rtl/sub_mp_seq.sv
// Multi-precision subtract sequencer: one 32-bit word per cycle
// through a shared external borrow-ripple subtractor, LSW first.
module sub_mp_seq #(
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  sub_mp_seq_if.slave io,
  output logic [31:0] sub_op1,
  output logic [31:0] sub_op2,
  output logic        sub_bo,
  input  logic [31:0] sub_diff,
  input  logic        sub_bi
);

  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int W  = 32 * WORDS;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            brw_q, brw_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    res_q, res_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      brw_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      brw_q   <= brw_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    brw_d          = brw_q;
    a_d            = a_q;
    b_d            = b_q;
    res_d          = res_q;
    io.start_ready = 1'b0;
    io.done_valid  = 1'b0;
    io.bout        = 1'b0;
    io.zero        = 1'b0;
    sub_op1        = '0;
    sub_op2        = '0;
    sub_bo         = 1'b0;
    unique case (state_q)
      IDLE: begin
        io.start_ready = 1'b1;
        if (io.start_valid) begin
          a_d     = io.a;
          b_d     = io.b;
          brw_d   = io.bin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sub_op1 = a_q[32*idx_q +: 32];
        sub_op2 = b_q[32*idx_q +: 32];
        sub_bo  = brw_q;
        res_d[32*idx_q +: 32] = sub_diff;
        brw_d = sub_bi;
        if (idx_q == IW'(WORDS - 1)) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        io.done_valid = 1'b1;
        io.bout       = brw_q;
        io.zero       = (res_q == '0);
        if (io.done_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign io.res = res_q;

endmodule

// File: tb/tb_sub_mp_seq.sv
// Directed bench for sub_mp_seq with a behavioural 32-bit
// borrow-ripple subtractor attached to the sub_* port.
module tb_sub_mp_seq;

  localparam int WORDS = 4;
  localparam int W     = 32 * WORDS;

  logic        clk;
  logic        rst;
  logic [31:0] sub_op1;
  logic [31:0] sub_op2;
  logic        sub_bo;
  logic [31:0] sub_diff;
  logic        sub_bi;
  logic [32:0] sub_full;

  int errors;
  int checks;

  sub_mp_seq_if #(.WORDS(WORDS)) io ();

  sub_mp_seq #(.WORDS(WORDS)) dut (
    .clk      (clk),
    .rst      (rst),
    .io       (io),
    .sub_op1  (sub_op1),
    .sub_op2  (sub_op2),
    .sub_bo   (sub_bo),
    .sub_diff (sub_diff),
    .sub_bi   (sub_bi)
  );

  assign sub_full = {1'b0, sub_op1} - {1'b0, sub_op2} - {32'd0, sub_bo};
  assign sub_diff = sub_full[31:0];
  assign sub_bi   = sub_full[32];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic issue(input logic [W-1:0] av,
                       input logic [W-1:0] bv,
                       input logic binv);
    @(negedge clk);
    io.start_valid = 1'b1;
    io.a   = av;
    io.b   = bv;
    io.bin = binv;
    @(negedge clk);
    io.start_valid = 1'b0;
    io.a   = '0;
    io.b   = '0;
    io.bin = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!io.done_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (io.done_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout: done_valid=%b required 1", name,
               io.done_valid);
    end
  endtask

  task automatic release_done();
    io.done_ready = 1'b1;
    @(negedge clk);
    io.done_ready = 1'b0;
  endtask

  task automatic check_result(input string name,
                              input logic [W-1:0] er,
                              input logic eb,
                              input logic ez);
    checks++;
    if (io.res !== er) begin
      errors++;
      $display("FAIL %s res: got %h required %h", name, io.res, er);
    end
    checks++;
    if (io.bout !== eb) begin
      errors++;
      $display("FAIL %s bout: got %b required %b", name, io.bout, eb);
    end
    checks++;
    if (io.zero !== ez) begin
      errors++;
      $display("FAIL %s zero: got %b required %b", name, io.zero, ez);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++;
    if ({io.start_ready, io.done_valid, io.bout, io.zero} !== 4'b1000) begin
      errors++;
      $display("FAIL reset flags: got %b required 1000",
               {io.start_ready, io.done_valid, io.bout, io.zero});
    end
    checks++;
    if (io.res !== '0) begin
      errors++;
      $display("FAIL reset res: got %h required 0", io.res);
    end
    checks++;
    if ({sub_op1, sub_op2, sub_bo} !== 65'd0) begin
      errors++;
      $display("FAIL reset sub: got %h %h %b required 0",
               sub_op1, sub_op2, sub_bo);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_word_borrow();
    issue(128'h1_0000_0000, 128'd1, 1'b0);
    wait_done("word_borrow");
    check_result("word_borrow", 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF,
                 1'b0, 1'b0);
    release_done();
  endtask

  task automatic test_full_ripple();
    issue(128'd0, 128'd1, 1'b0);
    wait_done("full_ripple");
    check_result("full_ripple", {W{1'b1}}, 1'b1, 1'b0);
    release_done();
  endtask

  task automatic test_equal();
    logic [W-1:0] v;
    v = 128'h12345678_9ABCDEF0_0F0F0F0F_FFFFFFFF;
    issue(v, v, 1'b0);
    wait_done("equal_bin0");
    check_result("equal_bin0", '0, 1'b0, 1'b1);
    release_done();
    issue(v, v, 1'b1);
    wait_done("equal_bin1");
    check_result("equal_bin1", {W{1'b1}}, 1'b1, 1'b0);
    release_done();
  endtask

  task automatic test_sequencing();
    logic [W-1:0] av;
    logic [W-1:0] bv;
    logic [31:0]  wa;
    av = 128'h44444444_33333333_22222222_11111111;
    bv = 128'h00000004_00000003_00000002_00000001;
    @(negedge clk);
    io.start_valid = 1'b1;
    io.a   = av;
    io.b   = bv;
    io.bin = 1'b1;
    @(negedge clk);
    io.start_valid = 1'b0;
    io.a   = '0;
    io.b   = '0;
    io.bin = 1'b0;
    for (int k = 0; k < WORDS; k++) begin
      wa = av[32*k +: 32];
      checks++;
      if (sub_op1 !== wa) begin
        errors++;
        $display("FAIL seq op1 word%0d: got %h required %h", k, sub_op1, wa);
      end
      checks++;
      if ({io.start_ready, io.done_valid} !== 2'b00) begin
        errors++;
        $display("FAIL seq flags word%0d: got %b required 00", k,
                 {io.start_ready, io.done_valid});
      end
      if (k == 0) begin
        checks++;
        if (sub_bo !== 1'b1) begin
          errors++;
          $display("FAIL seq bo word0: got %b required 1", sub_bo);
        end
      end
      @(negedge clk);
    end
    checks++;
    if ({io.start_ready, io.done_valid} !== 2'b01) begin
      errors++;
      $display("FAIL seq done: got %b required 01",
               {io.start_ready, io.done_valid});
    end
    check_result("seq", 128'h44444440_33333330_22222220_1111110F,
                 1'b0, 1'b0);
    checks++;
    if ({sub_op1, sub_bo} !== 33'd0) begin
      errors++;
      $display("FAIL seq sub idle in DONE: got %h %b required 0",
               sub_op1, sub_bo);
    end
    release_done();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] er;
    er = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE;
    issue(128'd5, 128'd7, 1'b0);
    wait_done("bp");
    for (int k = 0; k < 5; k++) begin
      io.start_valid = k[0];
      io.a   = 128'd99;
      io.b   = 128'd1;
      checks++;
      if ({io.done_valid, io.start_ready} !== 2'b10) begin
        errors++;
        $display("FAIL bp flags cyc%0d: got %b required 10", k,
                 {io.done_valid, io.start_ready});
      end
      check_result("bp_hold", er, 1'b1, 1'b0);
      @(negedge clk);
    end
    io.start_valid = 1'b0;
    io.a = '0;
    io.b = '0;
    release_done();
    checks++;
    if ({io.done_valid, io.start_ready} !== 2'b01) begin
      errors++;
      $display("FAIL bp exit: got %b required 01",
               {io.done_valid, io.start_ready});
    end
    checks++;
    if (io.res !== er) begin
      errors++;
      $display("FAIL bp retained res: got %h required %h", io.res, er);
    end
  endtask

  task automatic test_back_to_back();
    issue(128'd100, 128'd1, 1'b0);
    wait_done("b2b_first");
    check_result("b2b_first", 128'd99, 1'b0, 1'b0);
    release_done();
    issue(128'd3, 128'd3, 1'b0);
    wait_done("b2b_second");
    check_result("b2b_second", 128'd0, 1'b0, 1'b1);
    release_done();
  endtask

  task automatic test_reset_mid_run();
    issue({4{32'hDEADBEEF}}, 128'd1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({io.start_ready, io.done_valid, io.bout, io.zero} !== 4'b1000) begin
      errors++;
      $display("FAIL midrst flags: got %b required 1000",
               {io.start_ready, io.done_valid, io.bout, io.zero});
    end
    checks++;
    if (io.res !== '0 || sub_op1 !== 32'd0 || sub_bo !== 1'b0) begin
      errors++;
      $display("FAIL midrst clear: res %h op1 %h bo %b required 0",
               io.res, sub_op1, sub_bo);
    end
    @(negedge clk);
    rst = 1'b0;
    issue(128'd7, 128'd4, 1'b1);
    wait_done("after_rst");
    check_result("after_rst", 128'd2, 1'b0, 1'b0);
    release_done();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    io.start_valid = 1'b0;
    io.a = '0;
    io.b = '0;
    io.bin = 1'b0;
    io.done_ready = 1'b0;
    test_reset();
    test_word_borrow();
    test_full_ripple();
    test_equal();
    test_sequencing();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sub_mp_seq.md
Name: sub_mp_seq

Overview:
Multi-precision subtraction sequencer. It computes a WORDS×32-bit difference by time-multiplexing one external 32-bit borrow-ripple subtractor (op1, op2, bo → diff, bi), one word per cycle, least-significant word first. The block registers the operands, chains the borrow between words, assembles the result, and hands it off over a valid/ready pair. It sits between the ALU issue logic and the shared 32-bit subtractor instance.

Parameters:
WORDS, 4, number of 32-bit words per operand (≥1; default gives 128-bit subtraction)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
start_valid  input  1  request carries valid a, b, bin
start_ready  output  1  block can accept a request
a  input  32*WORDS  minuend, word k = a[32k+31:32k]
b  input  32*WORDS  subtrahend
bin  input  1  initial borrow-in into word 0
res  output  32*WORDS  a − b − bin, modulo 2^(32*WORDS)
bout  output  1  final borrow-out from the top word
zero  output  1  res == 0
done_valid  output  1  res, bout and zero are valid
done_ready  input  1  consumer accepts the result
sub_op1  output  32  to subtractor op1
sub_op2  output  32  to subtractor op2
sub_bo  output  1  to subtractor borrow-in (bo)
sub_diff  input  32  from subtractor diff (combinational, op1 − op2 − bo)
sub_bi  input  1  from subtractor borrow-out (bi)

Behaviour:
- Reset (async, rst=1): state=IDLE, idx=0, borrow reg=0, a/b/res regs=0. Outputs: start_ready=1, done_valid=0, res=0, bout=0, zero=0, sub_* outputs=0. Reset asserted mid-RUN or mid-DONE aborts immediately. No partial result is ever presented.
- FSM states: IDLE, RUN, DONE.
- IDLE: start_ready=1. If start_valid=1 at a clock edge: capture a, b into regs, brw<=bin, idx<=0, go to RUN.
- RUN: start_ready=0.
  - sub_op1 = a_reg word idx, sub_op2 = b_reg word idx, sub_bo = brw.
  - Each edge: res word idx <= sub_diff, brw <= sub_bi, idx <= idx+1.
  - On the edge where idx==WORDS-1: go to DONE, idx<=0.
- DONE: done_valid=1, bout=brw, zero=(res==0). Outputs stay stable while done_ready=0. On an edge with done_ready=1, go to IDLE; res is retained until the next RUN overwrites it.
- Latency: the accepting edge is E0. done_valid is high after edge E0+WORDS. Exactly WORDS RUN cycles occur. WORDS=1 means one RUN cycle.
- Throughput: no overlap. A new request is accepted at the earliest one cycle after the done handshake, because start_ready=0 in DONE.
- sub_op1, sub_op2 and sub_bo are 0 outside RUN.
- start_valid in RUN or DONE is ignored. a, b and bin may change freely after acceptance.
- idx width is max(1, clog2(WORDS)). Word arithmetic wraps modulo 2^32, and the borrow carries the wrap.
- bout=1 iff unsigned a < b + bin.

Test Plan:
1. WORDS=4, a=0x1_00000000, b=1, bin=0 → res=0x00000000_00000000_00000000_FFFFFFFF, bout=0, zero=0. Checks borrow propagation from word 0 into word 1.
2. a=0, b=1, bin=0 → res=all 0xFFFFFFFF (128 bits), bout=1, zero=0. Checks the borrow ripples through all 4 words.
3. a=b=0x12345678_9ABCDEF0_0F0F0F0F_FFFFFFFF, bin=0 → res=0, zero=1, bout=0. Same operands with bin=1 → res=all F, bout=1, zero=0.
4. Sequencing and latency: accept at edge E0.
   - sub_op1 shows a words 0,1,2,3 on successive cycles.
   - sub_bo on word 0 equals bin.
   - done_valid rises after E0+4.
   - start_ready low from E0 until DONE exits.
5. Backpressure: hold done_ready=0 for 5 cycles while pulsing start_valid → done_valid, res, bout and zero stay stable, no new capture. done_ready=1 → IDLE next cycle, start_ready=1.
6. Reset mid-RUN (idx=2): assert rst between edges → outputs clear immediately, state=IDLE. A subsequent request with a=7, b=4, bin=1 → res=2, bout=0.
